// File: rtl/gp_pkg.sv
// Shared definitions for the graphics-primitive (GP) command path: field widths,
// opcodes, screen limits and the arbiter state encoding.
package gp_pkg;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int ARG_W = 12;
    localparam int ID_W  = 3;

    localparam logic GP_FILL  = 1'b0;
    localparam logic GP_FRAME = 1'b1;

    localparam logic [X_W-1:0] SCREEN_X_MAX = 10'd639;
    localparam logic [Y_W-1:0] SCREEN_Y_MAX = 9'd479;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/gp_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first requester found searching
// upward from last+1 (wrapping at NREQ-1) wins.
module rr_pick
    import gp_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    localparam int SW = ID_W + 1;

    logic [ID_W-1:0] cand [NREQ];
    logic [NREQ-1:0] cand_hit;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [SW-1:0] sum;
            // last never exceeds NREQ-1, so one conditional subtract is a full modulo
            assign sum = {1'b0, last} + SW'(gi + 1);
            assign cand[gi] = (sum >= SW'(NREQ)) ? ID_W'(sum - SW'(NREQ)) : ID_W'(sum);

            always_comb begin
                cand_hit[gi] = 1'b0;
                for (int j = 0; j < NREQ; j++) begin
                    if (cand[gi] == ID_W'(j)) begin
                        cand_hit[gi] = req[j];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand[i];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gp_arbiter.sv
// Round-robin arbiter sharing one GP engine among NREQ command sources.
// Optional command watchdog enabled by defining GP_ARB_TIMEOUT_EN.
module gp_arbiter
    import gp_pkg::*;
#(
    parameter int          NREQ    = 3,
    parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_opcode,
    input  logic [NREQ*X_W-1:0]   req_tl_x,
    input  logic [NREQ*Y_W-1:0]   req_tl_y,
    input  logic [NREQ*X_W-1:0]   req_br_x,
    input  logic [NREQ*Y_W-1:0]   req_br_y,
    input  logic [NREQ*ARG_W-1:0] req_arg,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [ID_W-1:0]       grant_id,
    output logic                  gp_en,
    output logic                  gp_opcode,
    output logic [X_W-1:0]        gp_tl_x,
    output logic [Y_W-1:0]        gp_tl_y,
    output logic [X_W-1:0]        gp_br_x,
    output logic [Y_W-1:0]        gp_br_y,
    output logic [ARG_W-1:0]      gp_arg,
    input  logic                  gp_finish,
    output logic                  timeout_err
);

    arb_state_t       state_reg, state_next;
    logic [ID_W-1:0]  last_reg, last_next;
    logic [ID_W-1:0]  grant_reg, grant_next;
    logic             en_reg, en_next;
    logic [NREQ-1:0]  ack_reg, ack_next;
    logic             terr_reg, terr_next;
    logic             op_reg, op_next;
    logic [X_W-1:0]   tl_x_reg, tl_x_next, br_x_reg, br_x_next;
    logic [Y_W-1:0]   tl_y_reg, tl_y_next, br_y_reg, br_y_next;
    logic [ARG_W-1:0] arg_reg, arg_next;

    logic [ID_W-1:0]  winner;
    logic             any_req;
    logic             tmo_hit;

    logic             sel_op;
    logic [X_W-1:0]   sel_tl_x, sel_br_x;
    logic [Y_W-1:0]   sel_tl_y, sel_br_y;
    logic [ARG_W-1:0] sel_arg;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .last   (last_reg),
        .winner (winner),
        .any    (any_req)
    );

    always_comb begin
        sel_op   = 1'b0;
        sel_tl_x = '0;
        sel_tl_y = '0;
        sel_br_x = '0;
        sel_br_y = '0;
        sel_arg  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_op   = req_opcode[i];
                sel_tl_x = req_tl_x[i*X_W +: X_W];
                sel_tl_y = req_tl_y[i*Y_W +: Y_W];
                sel_br_x = req_br_x[i*X_W +: X_W];
                sel_br_y = req_br_y[i*Y_W +: Y_W];
                sel_arg  = req_arg[i*ARG_W +: ARG_W];
            end
        end
    end

`ifdef GP_ARB_TIMEOUT_EN
    logic [19:0] cnt_reg, cnt_next;

    // Counter sits at zero outside ISSUE, so every grant starts a fresh count.
    assign cnt_next = (state_reg == ARB_ISSUE) ? cnt_reg + 20'd1 : '0;
    assign tmo_hit  = (state_reg == ARB_ISSUE) && (cnt_reg == TIMEOUT - 20'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        grant_next = grant_reg;
        en_next    = en_reg;
        ack_next   = '0;
        terr_next  = 1'b0;
        op_next    = op_reg;
        tl_x_next  = tl_x_reg;
        tl_y_next  = tl_y_reg;
        br_x_next  = br_x_reg;
        br_y_next  = br_y_reg;
        arg_next   = arg_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (any_req) begin
                    op_next    = sel_op;
                    tl_x_next  = sel_tl_x;
                    tl_y_next  = sel_tl_y;
                    br_x_next  = sel_br_x;
                    br_y_next  = sel_br_y;
                    arg_next   = sel_arg;
                    grant_next = winner;
                    last_next  = winner;
                    en_next    = 1'b1;
                    state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (gp_finish || tmo_hit) begin
                    en_next    = 1'b0;
                    ack_next   = {{(NREQ-1){1'b0}}, 1'b1} << grant_reg;
                    terr_next  = !gp_finish;
                    state_next = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                en_next = 1'b0;
                if (!gp_finish) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                en_next    = 1'b0;
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARB_IDLE;
            last_reg  <= ID_W'(NREQ - 1);
            grant_reg <= '0;
            en_reg    <= 1'b0;
            ack_reg   <= '0;
            terr_reg  <= 1'b0;
            op_reg    <= 1'b0;
            tl_x_reg  <= '0;
            tl_y_reg  <= '0;
            br_x_reg  <= '0;
            br_y_reg  <= '0;
            arg_reg   <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            grant_reg <= grant_next;
            en_reg    <= en_next;
            ack_reg   <= ack_next;
            terr_reg  <= terr_next;
            op_reg    <= op_next;
            tl_x_reg  <= tl_x_next;
            tl_y_reg  <= tl_y_next;
            br_x_reg  <= br_x_next;
            br_y_reg  <= br_y_next;
            arg_reg   <= arg_next;
        end
    end

    assign busy        = (state_reg != ARB_IDLE);
    assign grant_id    = grant_reg;
    assign gp_en       = en_reg;
    assign ack         = ack_reg;
    assign timeout_err = terr_reg;
    assign gp_opcode   = op_reg;
    assign gp_tl_x     = tl_x_reg;
    assign gp_tl_y     = tl_y_reg;
    assign gp_br_x     = br_x_reg;
    assign gp_br_y     = br_y_reg;
    assign gp_arg      = arg_reg;

endmodule

// File: tb/tb_gp_arbiter.sv
// Directed bench for gp_arbiter: vector table of grants plus reset and
// watchdog sequences (watchdog only when GP_ARB_TIMEOUT_EN is defined).
module tb_gp_arbiter;
    import gp_pkg::*;

    localparam int NREQ = 3;
`ifdef GP_ARB_TIMEOUT_EN
    localparam logic [19:0] TMO = 20'd100;
`else
    localparam logic [19:0] TMO = 20'hFFFFF;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       req_opcode;
    logic [NREQ*X_W-1:0]   req_tl_x;
    logic [NREQ*Y_W-1:0]   req_tl_y;
    logic [NREQ*X_W-1:0]   req_br_x;
    logic [NREQ*Y_W-1:0]   req_br_y;
    logic [NREQ*ARG_W-1:0] req_arg;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [ID_W-1:0]       grant_id;
    logic                  gp_en;
    logic                  gp_opcode;
    logic [X_W-1:0]        gp_tl_x;
    logic [Y_W-1:0]        gp_tl_y;
    logic [X_W-1:0]        gp_br_x;
    logic [Y_W-1:0]        gp_br_y;
    logic [ARG_W-1:0]      gp_arg;
    logic                  gp_finish = 1'b0;
    logic                  timeout_err;

    gp_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_opcode  (req_opcode),
        .req_tl_x    (req_tl_x),
        .req_tl_y    (req_tl_y),
        .req_br_x    (req_br_x),
        .req_br_y    (req_br_y),
        .req_arg     (req_arg),
        .ack         (ack),
        .busy        (busy),
        .grant_id    (grant_id),
        .gp_en       (gp_en),
        .gp_opcode   (gp_opcode),
        .gp_tl_x     (gp_tl_x),
        .gp_tl_y     (gp_tl_y),
        .gp_br_x     (gp_br_x),
        .gp_br_y     (gp_br_y),
        .gp_arg      (gp_arg),
        .gp_finish   (gp_finish),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [2:0]  mask;
        logic [2:0]  late;
        int          fin_delay;
        int          hold;
        int          id;
        logic        op;
        logic [9:0]  tlx;
        logic [8:0]  tly;
        logic [9:0]  brx;
        logic [8:0]  bry;
        logic [11:0] arg;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit rst, logic [2:0] mask, logic [2:0] late, int d, int h,
                                int id, logic op, logic [9:0] tlx, logic [8:0] tly,
                                logic [9:0] brx, logic [8:0] bry, logic [11:0] arg);
        vec_t v;
        v.rst = rst; v.mask = mask; v.late = late; v.fin_delay = d; v.hold = h;
        v.id = id; v.op = op; v.tlx = tlx; v.tly = tly; v.brx = brx; v.bry = bry; v.arg = arg;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        gp_finish = 1'b0;
        req = '0;
        #2;
        chk("rst_gp_en", 32'(gp_en), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_fields", {gp_tl_x, gp_tl_y, gp_arg}, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_fields(input string tag, input vec_t v);
        chk({tag, "_opcode"}, 32'(gp_opcode), 32'(v.op));
        chk({tag, "_tl_x"}, 32'(gp_tl_x), 32'(v.tlx));
        chk({tag, "_tl_y"}, 32'(gp_tl_y), 32'(v.tly));
        chk({tag, "_br_x"}, 32'(gp_br_x), 32'(v.brx));
        chk({tag, "_br_y"}, 32'(gp_br_y), 32'(v.bry));
        chk({tag, "_arg"}, 32'(gp_arg), 32'(v.arg));
    endtask

    task automatic run_vec(input int n, input vec_t v);
        bit got;
        int en_cycles;
        logic [2:0] exp_ack;
        if (v.rst) do_reset();
        req = v.mask;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (gp_en) got = 1;
        end
        chk("grant_seen", 32'(got), 32'd1);
        if (!got) return;
        exp_ack = 3'b001 << v.id;
        en_cycles = 1;
        chk("grant_id", 32'(grant_id), 32'(v.id));
        chk("busy_issue", 32'(busy), 32'd1);
        chk("ack_at_grant", 32'(ack), 32'd0);
        check_fields("grant", v);
        for (int k = 1; k < v.fin_delay; k++) begin
            if (k == 1) req = req | v.late;
            tick();
            if (gp_en) en_cycles++;
            chk("ack_during_issue", 32'(ack), 32'd0);
        end
        check_fields("held", v);
        chk("gp_en_cycles", 32'(en_cycles), 32'(v.fin_delay));
        gp_finish = 1'b1;
        tick();
        chk("gp_en_after_finish", 32'(gp_en), 32'd0);
        chk("ack_pulse", 32'(ack), 32'(exp_ack));
        chk("busy_release", 32'(busy), 32'd1);
        req = req & ~exp_ack;
        for (int k = 0; k < v.hold; k++) begin
            tick();
            chk("release_busy", 32'(busy), 32'd1);
            chk("release_ack", 32'(ack), 32'd0);
            chk("release_gp_en", 32'(gp_en), 32'd0);
        end
        gp_finish = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ack", 32'(ack), 32'd0);
        $display("txn %0d: grant_id=%0d exp=%0d en_cycles=%0d hold=%0d", n, grant_id, v.id, en_cycles, v.hold);
    endtask

    initial begin
        req_opcode = 3'b101;
        req_tl_x   = {10'd639, 10'd0,   10'd10};
        req_tl_y   = {9'd479,  9'd0,    9'd20};
        req_br_x   = {10'd0,   10'd639, 10'd100};
        req_br_y   = {9'd0,    9'd479,  9'd200};
        req_arg    = {12'h123, 12'hFFF, 12'h0F0};

        //            rst mask    late    D   h  id  op         tlx      tly     brx      bry     arg
        vecs[0]  = mk(1, 3'b010, 3'b000, 10, 0, 1, GP_FILL,  10'd0,   9'd0,   10'd639, 9'd479, 12'hFFF);
        vecs[1]  = mk(1, 3'b111, 3'b000, 3,  0, 0, GP_FRAME, 10'd10,  9'd20,  10'd100, 9'd200, 12'h0F0);
        vecs[2]  = mk(0, 3'b111, 3'b000, 1,  0, 1, GP_FILL,  10'd0,   9'd0,   10'd639, 9'd479, 12'hFFF);
        vecs[3]  = mk(0, 3'b111, 3'b000, 2,  0, 2, GP_FRAME, 10'd639, 9'd479, 10'd0,   9'd0,   12'h123);
        vecs[4]  = mk(0, 3'b111, 3'b000, 1,  0, 0, GP_FRAME, 10'd10,  9'd20,  10'd100, 9'd200, 12'h0F0);
        vecs[5]  = mk(0, 3'b111, 3'b000, 4,  0, 1, GP_FILL,  10'd0,   9'd0,   10'd639, 9'd479, 12'hFFF);
        vecs[6]  = mk(0, 3'b111, 3'b000, 1,  0, 2, GP_FRAME, 10'd639, 9'd479, 10'd0,   9'd0,   12'h123);
        vecs[7]  = mk(0, 3'b001, 3'b100, 6,  0, 0, GP_FRAME, 10'd10,  9'd20,  10'd100, 9'd200, 12'h0F0);
        vecs[8]  = mk(0, 3'b100, 3'b000, 2,  5, 2, GP_FRAME, 10'd639, 9'd479, 10'd0,   9'd0,   12'h123);
        vecs[9]  = mk(0, 3'b011, 3'b000, 1,  0, 0, GP_FRAME, 10'd10,  9'd20,  10'd100, 9'd200, 12'h0F0);
        vecs[10] = mk(0, 3'b011, 3'b000, 1,  1, 1, GP_FILL,  10'd0,   9'd0,   10'd639, 9'd479, 12'hFFF);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Asynchronous reset in the middle of a command: last is 1, so requester 2 wins first.
        begin
            bit got = 0;
            req = 3'b100;
            for (int k = 0; k < 20 && !got; k++) begin
                tick();
                if (gp_en) got = 1;
            end
            chk("pre_reset_grant", {31'd0, got}, 32'd1);
            chk("pre_reset_grant_id", 32'(grant_id), 32'd2);
            tick();
            tick();
            #2;
            rst_n = 1'b0;
            #1;
            chk("reset_mid_gp_en", 32'(gp_en), 32'd0);
            chk("reset_mid_ack", 32'(ack), 32'd0);
            chk("reset_mid_busy", 32'(busy), 32'd0);
            req = '0;
            repeat (2) @(negedge clk);
            chk("reset_hold_ack", 32'(ack), 32'd0);
            rst_n = 1'b1;
            $display("txn reset_mid_issue: gp_en=%0d ack=%0b", gp_en, ack);
            run_vec(11, mk(0, 3'b111, 3'b000, 2, 0, 0, GP_FRAME, 10'd10, 9'd20, 10'd100, 9'd200, 12'h0F0));
            req = '0;
        end

`ifdef GP_ARB_TIMEOUT_EN
        // Engine never finishes: watchdog must abort after TMO cycles of gp_en.
        begin
            int en_cnt = 0;
            int err_pulses = 0;
            int ack_pulses = 0;
            req = 3'b010;
            for (int k = 0; k < 300; k++) begin
                tick();
                if (timeout_err) err_pulses++;
                if (ack != 3'b000) begin
                    ack_pulses++;
                    chk("timeout_ack_value", 32'(ack), 32'd2);
                    req = '0;
                end
                if (gp_en) en_cnt++;
                else if (en_cnt > 0 && k > en_cnt + 3) break;
            end
            chk("timeout_en_cycles", 32'(en_cnt), 32'd100);
            chk("timeout_err_pulses", 32'(err_pulses), 32'd1);
            chk("timeout_ack_pulses", 32'(ack_pulses), 32'd1);
            chk("timeout_idle", 32'(busy), 32'd0);
            $display("txn timeout: en_cycles=%0d err_pulses=%0d ack_pulses=%0d", en_cnt, err_pulses, ack_pulses);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gp_arbiter.md
# gp_arbiter

Shares the single graphics-primitive (GP) engine among NREQ independent command sources: game-state painting, note-lane rendering and score overlay. Each requester presents a complete rectangle command and a request line. The arbiter grants one requester at a time, using round-robin order. It latches the granted command and drives it onto the GP port, runs the `gp_en`/`gp_finish` handshake, and returns a one-cycle `ack` to the owner. It sits between the game controller and related painters on one side and the GP engine on the other.

## Interface
- `NREQ`, 3: number of requesters, 2..8.
- `TIMEOUT`, 20'hFFFFF: maximum number of cycles `gp_en` may be held without `gp_finish`. Used only with GP_ARB_TIMEOUT_EN.
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-requester command request. Held high until that requester's `ack`.
- `req_opcode` in NREQ: per-requester GP opcode.
- `req_tl_x` in NREQ*10: per-requester top-left x. Requester i occupies slice [10i+9:10i].
- `req_tl_y` in NREQ*9: per-requester top-left y.
- `req_br_x` in NREQ*10: per-requester bottom-right x.
- `req_br_y` in NREQ*9: per-requester bottom-right y.
- `req_arg` in NREQ*12: per-requester argument (RGB444 colour).
- `ack` out NREQ: one-cycle completion pulse to the granted requester.
- `busy` out 1: high whenever the state is not IDLE.
- `grant_id` out 3: index of the current or last granted requester.
- `gp_en` out 1: command valid to the GP engine.
- `gp_opcode` out 1, `gp_tl_x` out 10, `gp_tl_y` out 9, `gp_br_x` out 10, `gp_br_y` out 9, `gp_arg` out 12: latched command to the GP engine.
- `gp_finish` in 1: GP engine done. Stays high until `gp_en` falls.
- `timeout_err` out 1: one-cycle pulse when a command is aborted by timeout.

## Operation
- States:
  - IDLE: no command in flight.
  - ISSUE: `gp_en` high, waiting for `gp_finish`.
  - RELEASE: `gp_en` low, waiting for `gp_finish` to fall.
- IDLE with any `req` bit high:
  - Select the winner by round robin, searching from `last+1` upward and wrapping at NREQ-1 to 0.
  - Latch the winner's command fields into the `gp_*` registers.
  - Set `grant_id` and `last` to the winner.
  - Set `gp_en`=1 and go to ISSUE.
- ISSUE with `gp_finish`=1:
  - `gp_en`=0.
  - `ack[grant_id]`=1 for one cycle.
  - Go to RELEASE.
- ISSUE without `gp_finish`: command registers hold steady. They are never changed while `gp_en`=1.
- RELEASE with `gp_finish`=0: go to IDLE. The minimum stay in RELEASE is one cycle.
- Requests arriving during ISSUE or RELEASE wait. A `req` that drops before it is granted is simply not served.
- Reset values, asserted asynchronously:
  - State IDLE, `last`=NREQ-1, so the first grant after reset goes to requester 0.
  - All outputs 0.
  - Reset in the middle of ISSUE drops `gp_en` immediately and sends no `ack`.
- Coordinates are passed through unchanged. No range checks and no tl/br swapping.

## Timing
- `req` high at edge n (state IDLE) → `gp_en`=1 and fields valid after edge n.
- `gp_finish` sampled high at edge m → `gp_en`=0 and `ack`=1 during cycle m..m+1.
- Earliest possible re-grant is edge m+2, which requires `gp_finish` low at m+1.
- A requester drops `req` on the edge after it sees `ack`. IDLE evaluation never occurs earlier than that, so a served request is never granted twice.
- Fairness: with all requesters permanently requesting, each is served once in every NREQ grants.

## Configuration
- `GP_ARB_TIMEOUT_EN` defined:
  - A 20-bit counter clears on entry to ISSUE and increments every ISSUE cycle.
  - On reaching TIMEOUT: `gp_en`=0, `timeout_err`=1 for one cycle, `ack[grant_id]`=1 for one cycle, go to RELEASE.
- Not defined:
  - No counter exists. `timeout_err` is tied to 0.
  - ISSUE waits indefinitely for `gp_finish`.

## Structure
- Shared package `gp_pkg`:
  - Field widths: X_W=10, Y_W=9, ARG_W=12.
  - Opcode constants: GP_FILL=0, GP_FRAME=1.
  - Arbiter state encoding.
  - Screen limits 639/479.
- One sub-module, `rr_pick`: combinational rotating-priority picker. Inputs `req` and `last`; outputs `winner` index and `any`.

## Test plan
- Single requester: `req[1]` with FILL (0,0)-(639,479), arg 12'hFFF; GP model finishes after 10 cycles → `gp_en` high 10 cycles with exact fields, `ack[1]` single pulse, `grant_id`=1.
- All three requesting continuously (`req`=3'b111) from reset → grant order 0,1,2,0,1,2. Each `ack` matches its grant.
- Request from requester 2 arriving while requester 0 is in ISSUE → `gp_*` fields stay unchanged until `ack[0]`. Requester 2 is granted after RELEASE.
- `gp_finish` held high for 5 cycles after completion → state stays in RELEASE for 5 cycles, then re-grant. Exactly one `ack`.
- `rst_n` pulsed low mid-ISSUE → `gp_en`=0 immediately, no `ack`. The next grant goes to requester 0.
- With GP_ARB_TIMEOUT_EN and TIMEOUT=100, GP never finishes → `gp_en` falls after 100 ISSUE cycles. `timeout_err` and `ack` each pulse once.
